// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed, double-buffered scan controller for a common-anode FND bank.
// Optional leading-zero blanking is enabled by defining FND_LZB_EN.
module fnd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD_CYC   = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic [3:0]              number,
  output logic [NUM_DIGITS-1:0]   fnd_com,
  output logic                    frame_tick,
  output logic                    upd_ack
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {S_OFF, S_DEAD, S_ON} state_t;

  state_t                  state;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_d;
  logic [4*NUM_DIGITS-1:0] pend, pend_d;
  logic                    pend_valid, pend_valid_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic [IW-1:0]           idx, idx_d;
  logic [3:0]              number_d;
  logic [NUM_DIGITS-1:0]   fnd_com_d;
  logic                    frame_tick_d, upd_ack_d;
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   sel, blank;
  logic                    slot_end, wrap;

  // Phase within the slot is a pure decode of the enable and slot counter.
  always_comb begin
    if (!en)                       state = S_OFF;
    else if (cnt < CW'(DEAD_CYC))  state = S_DEAD;
    else                           state = S_ON;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cur_nib = 4'h0;
    sel     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = shadow[4*i +: 4];
        sel[i]  = 1'b1;
      end
    end
  end

`ifdef FND_LZB_EN
  // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
  logic zero_above;
  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (shadow[4*i +: 4] == 4'h0);
      blank[i]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  assign slot_end = (cnt == CW'(SCAN_DIV - 1));
  assign wrap     = slot_end && (idx == IW'(NUM_DIGITS - 1));

  always_comb begin
    shadow_d     = shadow;
    pend_d       = pend;
    pend_valid_d = pend_valid;
    cnt_d        = cnt;
    idx_d        = idx;
    number_d     = 4'h0;
    fnd_com_d    = '1;
    frame_tick_d = 1'b0;
    upd_ack_d    = 1'b0;

    case (state)
      S_OFF: begin
        cnt_d = '0;
        idx_d = '0;
        // While dark there is no frame to tear, so a load is shown at once.
        if (load) begin
          shadow_d     = value;
          pend_valid_d = 1'b0;
          upd_ack_d    = 1'b1;
        end
      end
      S_DEAD, S_ON: begin
        number_d = cur_nib;
        if (state == S_ON) fnd_com_d = ~(sel & ~blank);

        if (slot_end) begin
          cnt_d = '0;
          idx_d = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end

        // Commit of the old staged value happens before a same-edge load restages it.
        if (wrap) begin
          frame_tick_d = 1'b1;
          if (pend_valid) begin
            shadow_d     = pend;
            pend_valid_d = 1'b0;
            upd_ack_d    = 1'b1;
          end
        end
        if (load) begin
          pend_d       = value;
          pend_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: every register, including the staged value, is reset so a pending update is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      number     <= 4'h0;
      fnd_com    <= '1;
      frame_tick <= 1'b0;
      upd_ack    <= 1'b0;
    end else begin
      shadow     <= shadow_d;
      pend       <= pend_d;
      pend_valid <= pend_valid_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      number     <= number_d;
      fnd_com    <= fnd_com_d;
      frame_tick <= frame_tick_d;
      upd_ack    <= upd_ack_d;
    end
  end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Time-multiplexed scan controller for a common-anode 7-segment (FND) display bank. It holds a multi-digit hex value and steps through the digits one at a time. For each digit it drives the 4-bit nibble to the downstream `fnd_encoder` and the matching active-low common line. It sits between the arithmetic datapath, which produces results with a `load` strobe, and the board FND pins. Updates are double-buffered so a frame never shows a mix of old and new digits.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned; must be ≥2.
- `SCAN_DIV`, 50000: clock cycles per digit slot; must be >`DEAD_CYC`.
- `DEAD_CYC`, 500: blanking cycles at the start of each slot (anti-ghosting); must be ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `en` in 1: scan enable.
- `load` in 1: one-cycle strobe; `value` is captured on this edge.
- `value` in 4·NUM_DIGITS: hex digits, digit 0 = bits [3:0] (rightmost).
- `number` out 4: nibble for `fnd_encoder`.
- `fnd_com` out NUM_DIGITS: digit commons, active-low; bit i = digit i.
- `frame_tick` out 1: one-cycle pulse at frame wrap.
- `upd_ack` out 1: one-cycle pulse when a pending value becomes visible.

## Operation
- Registers:
  - `shadow`: the displayed value.
  - `pend` and `pend_valid`: the staged value and its flag.
  - `cnt`: slot counter, 0..SCAN_DIV-1.
  - `idx`: digit index, 0..NUM_DIGITS-1.
- States:
  - OFF: `en`=0.
  - DEAD: `cnt` < DEAD_CYC.
  - ON: otherwise.
- OFF behaviour:
  - `cnt`=0, `idx`=0, `fnd_com` all ones, `number`=0.
  - A `load` writes `shadow` directly. `pend_valid` is cleared and `upd_ack` pulses on the next cycle.
- OFF→DEAD: occurs on the first cycle `en`=1, starting at digit 0, `cnt`=0.
- Any state→OFF: occurs on `en`=0 at the next edge, regardless of slot position.
- `cnt` increments every enabled cycle. At `cnt`=SCAN_DIV-1 it returns to 0 and `idx` advances.
- `idx` wraps NUM_DIGITS-1→0. That wrap edge is the frame boundary.
- Frame boundary: `frame_tick`=1 for one cycle. If `pend_valid`, then `shadow`←`pend`, `pend_valid`←0, and `upd_ack`=1 in the same cycle as `frame_tick`.
- `load` while enabled: `pend`←`value`, `pend_valid`←1.
  - Repeated loads within a frame: the last one wins.
  - A `load` on the same edge as the frame boundary goes to `pend`. The boundary commits the previous `pend`, if any, and the new value stays pending until the next boundary.
- DEAD: `fnd_com` all ones. `number` = `shadow` nibble `idx`.
- ON: `fnd_com` = all ones except bit `idx`=0. `number` = `shadow` nibble `idx`.

## Timing
- Reset values: `number`=0, `fnd_com`=all ones, `frame_tick`=0, `upd_ack`=0, `shadow`=0, `pend`=0, `pend_valid`=0, `cnt`=0, `idx`=0.
- `number`, `fnd_com`, `frame_tick` and `upd_ack` are registered. They reflect `cnt`/`idx` state with 1-cycle latency.
- Per slot: `fnd_com` is all ones for DEAD_CYC cycles, then active for SCAN_DIV−DEAD_CYC cycles.
- Frame period: NUM_DIGITS·SCAN_DIV cycles. `frame_tick` spacing equals the frame period exactly while `en`=1.
- Load-to-display latency is at most one frame plus one cycle. It is 1 cycle in OFF.
- An asynchronous `rst` mid-frame immediately forces all reset values, and any pending value is discarded.

## Configuration
- `FND_LZB_EN` defined: leading-zero blanking.
  - Digits above the highest nonzero digit keep their `fnd_com` bit high for the whole slot.
  - Digit 0 is always shown.
  - The decision uses `shadow`.
- `FND_LZB_EN` undefined: every digit lights in its ON phase.

## Test plan
Benches use NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYC=2.
- Reset: assert `rst` mid-stream → `fnd_com`=4'b1111, `number`=0, `frame_tick`=0, `upd_ack`=0 immediately.
- Basic scan: `en`=0, `load` 16'h1234, then `en`=1 → `number` sequence 4,3,2,1. `fnd_com` per slot is 1111×2 then 1110/1101/1011/0111×6. `frame_tick` every 32 cycles.
- Double-buffered update: `load` 16'hABCD at slot 2 → digits 2 and 3 still show 2 and 1. At wrap, `frame_tick` and `upd_ack` pulse together; the next frame shows D,C,B,A.
- Multiple loads: `load` 16'h1111 then 16'h2222 in one frame → one `upd_ack`; 2222 is displayed.
- Disable and boundary load:
  - `en`=0 mid-slot → `fnd_com`=1111 on the next cycle.
  - Re-enable → digit 0 restarts with 2 dead cycles.
  - `load` on the wrap edge → committed one frame later.
- Leading-zero blanking: 16'h0050 with `FND_LZB_EN` → digits 3 and 2 stay dark; digits 1 and 0 show 5 and 0. Without the macro → all four digits light.
